// File: rtl/adc_capture_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// adc_capture_pkg : shared types and widths for the ADC capture packer
// Revision 1.0
// ---------------------------------------------------------------------------
package adc_capture_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DONE    = 2'd3
  } cap_state_e;

  // Default sample width; modules derive their own accumulator width from ADC_W.
  localparam int ADC_W_DEF    = 12;
  localparam int ACC_W        = ADC_W_DEF + 3;
  localparam int SAMPLE_OUT_W = 16;

endpackage
`default_nettype wire

// File: rtl/adc_avg_decimator.sv
`default_nettype none
// ---------------------------------------------------------------------------
// adc_avg_decimator : sums 2^k samples, emits (sum >> k) one cycle later
// Revision 1.0
// ---------------------------------------------------------------------------
module adc_avg_decimator
  import adc_capture_pkg::*;
#(
  parameter int ADC_W = 12
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    clear,
  input  logic                    sample_en,
  input  logic [ADC_W-1:0]        sample,
  input  logic [1:0]              dec_log2,
  output logic [SAMPLE_OUT_W-1:0] avg_sample,
  output logic                    avg_valid
);

  localparam int SUM_W = ADC_W + 3;

  logic [SUM_W-1:0]        acc_q, acc_d, sum;
  logic [2:0]              cnt_q, cnt_d, last_cnt;
  logic [SAMPLE_OUT_W-1:0] avg_sample_q, avg_sample_d;
  logic                    avg_valid_q, avg_valid_d;

  always_comb begin
    sum          = acc_q + SUM_W'(sample);
    last_cnt     = 3'((4'd1 << dec_log2) - 4'd1);
    acc_d        = acc_q;
    cnt_d        = cnt_q;
    avg_sample_d = avg_sample_q;
    avg_valid_d  = 1'b0;
    if (clear) begin
      acc_d = '0;
      cnt_d = '0;
    end else if (sample_en) begin
      if (cnt_q == last_cnt) begin
        // Truncating average; the sum already includes the closing sample.
        avg_valid_d  = 1'b1;
        avg_sample_d = SAMPLE_OUT_W'(sum >> dec_log2);
        acc_d        = '0;
        cnt_d        = '0;
      end else begin
        acc_d = sum;
        cnt_d = cnt_q + 3'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      acc_q        <= '0;
      cnt_q        <= '0;
      avg_sample_q <= '0;
      avg_valid_q  <= 1'b0;
    end else begin
      acc_q        <= acc_d;
      cnt_q        <= cnt_d;
      avg_sample_q <= avg_sample_d;
      avg_valid_q  <= avg_valid_d;
    end
  end

  assign avg_sample = avg_sample_q;
  assign avg_valid  = avg_valid_q;

endmodule
`default_nettype wire

// File: rtl/adc_capture_packer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// adc_capture_packer : trigger/burst FSM, 2x16 word packer, overrun flag
// Revision 1.0
// ---------------------------------------------------------------------------
module adc_capture_packer
  import adc_capture_pkg::*;
#(
  parameter int ADC_W = 12,
  parameter int LEN_W = 16
) (
  input  logic              wrclock,
  input  logic              reset_n,
  input  logic [ADC_W-1:0]  adc_data,
  input  logic              adc_valid,
  input  logic              start,
  input  logic              abort,
  input  logic              trig,
  input  logic              cfg_trig_en,
  input  logic [1:0]        cfg_dec_log2,
  input  logic [LEN_W-1:0]  cfg_words,
  input  logic              fifo_full,
  output logic [31:0]       avalonst_source_data,
  output logic              avalonst_source_valid,
  output logic              busy,
  output logic              done,
  output logic              overrun
);

  cap_state_e              state_q, state_d;
  logic                    trig_en_q, trig_en_d;
  logic [1:0]              dec_log2_q, dec_log2_d;
  logic [LEN_W-1:0]        words_q, words_d;
  logic [LEN_W-1:0]        word_cnt_q, word_cnt_d, word_cnt_inc;
  logic                    half_q, half_d;
  logic [SAMPLE_OUT_W-1:0] low_q, low_d;
  logic [31:0]             data_q, data_d;
  logic                    valid_q, valid_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    overrun_q, overrun_d;
  logic                    start_ok;
  logic                    dec_clear;
  logic [SAMPLE_OUT_W-1:0] avg_sample;
  logic                    avg_valid;

  assign dec_clear = abort || (state_q != ST_CAPTURE);

  adc_avg_decimator #(
    .ADC_W (ADC_W)
  ) u_dec (
    .clk        (wrclock),
    .reset_n    (reset_n),
    .clear      (dec_clear),
    .sample_en  (adc_valid),
    .sample     (adc_data),
    .dec_log2   (dec_log2_q),
    .avg_sample (avg_sample),
    .avg_valid  (avg_valid)
  );

  always_comb begin
    state_d      = state_q;
    trig_en_d    = trig_en_q;
    dec_log2_d   = dec_log2_q;
    words_d      = words_q;
    word_cnt_d   = word_cnt_q;
    half_d       = half_q;
    low_d        = low_q;
    data_d       = data_q;
    valid_d      = 1'b0;
    overrun_d    = overrun_q || (valid_q && fifo_full);
    word_cnt_inc = word_cnt_q + LEN_W'(1);
    start_ok     = start && !abort && (state_q == ST_IDLE || state_q == ST_DONE);

    if (abort) begin
      state_d = ST_IDLE;
      half_d  = 1'b0;
    end else if (start_ok) begin
      trig_en_d  = cfg_trig_en;
      dec_log2_d = cfg_dec_log2;
      words_d    = cfg_words;
      word_cnt_d = '0;
      half_d     = 1'b0;
      overrun_d  = 1'b0;
      state_d    = cfg_trig_en ? ST_ARMED : ST_CAPTURE;
    end else begin
      case (state_q)
        ST_ARMED: if (trig) state_d = ST_CAPTURE;
        ST_CAPTURE: begin
          if (avg_valid) begin
            if (!half_q) begin
              low_d  = avg_sample;
              half_d = 1'b1;
            end else begin
              data_d     = {avg_sample, low_q};
              valid_d    = 1'b1;
              half_d     = 1'b0;
              word_cnt_d = word_cnt_inc;
              // A zero word count means continuous capture; the counter just wraps.
              if (words_q != '0 && word_cnt_inc == words_q) state_d = ST_DONE;
            end
          end
        end
        default: ;
      endcase
    end

    busy_d = (state_d == ST_ARMED) || (state_d == ST_CAPTURE);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge wrclock) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      trig_en_q  <= 1'b0;
      dec_log2_q <= '0;
      words_q    <= '0;
      word_cnt_q <= '0;
      half_q     <= 1'b0;
      low_q      <= '0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      trig_en_q  <= trig_en_d;
      dec_log2_q <= dec_log2_d;
      words_q    <= words_d;
      word_cnt_q <= word_cnt_d;
      half_q     <= half_d;
      low_q      <= low_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      overrun_q  <= overrun_d;
    end
  end

  assign avalonst_source_data  = data_q;
  assign avalonst_source_valid = valid_q;
  assign busy                  = busy_q;
  assign done                  = done_q;
  assign overrun               = overrun_q;

endmodule
`default_nettype wire
